// File: rtl/billiard_pkg.sv
// Shared types and defaults for the white-ball cue controller: FSM states,
// charge-mirror width and the per-axis saturating step helper.
package billiard_pkg;

  typedef enum logic [1:0] {
    WAIT_REST = 2'd0,
    AIM       = 2'd1,
    RELEASE   = 2'd2,
    WAIT_MOVE = 2'd3
  } cue_state_t;

  localparam int DEF_MAX_STEPS      = 5;
  localparam int DEF_REST_FRAMES    = 4;
  localparam int DEF_TIMEOUT_FRAMES = 8;
  localparam int CHARGE_W           = 4;

  typedef struct packed {
    logic                       inc;
    logic                       dec;
    logic signed [CHARGE_W-1:0] next;
  } axis_step_t;

  // Opposing edges on one axis cancel; a saturated direction is silently dropped.
  function automatic axis_step_t axis_step(input logic signed [CHARGE_W-1:0] cur,
                                           input logic rise_inc,
                                           input logic rise_dec,
                                           input int   max_steps);
    axis_step_t r;
    r.inc  = 1'b0;
    r.dec  = 1'b0;
    r.next = cur;
    if (rise_inc && !rise_dec && (int'(cur) < max_steps)) begin
      r.inc  = 1'b1;
      r.next = cur + 4'sd1;
    end else if (rise_dec && !rise_inc && (int'(cur) > -max_steps)) begin
      r.dec  = 1'b1;
      r.next = cur - 4'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one keyboard key level; history clears on reset.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic rise
);

  logic key_q;
  logic key_d;

  always_comb key_d = key;

  always_ff @(posedge clk) begin
    if (resetN) key_q <= 1'b0;
    else        key_q <= key_d;
  end

  assign rise = key & ~key_q;

endmodule

// File: rtl/shot_cue_controller.sv
// Turns key levels into single-cycle charge/release pulses for the ball-motion
// block, issuing commands only while the ball rests; mirrors the pending shot.
module shot_cue_controller
  import billiard_pkg::*;
#(
  parameter int MAX_STEPS      = DEF_MAX_STEPS,
  parameter int REST_FRAMES    = DEF_REST_FRAMES,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       keyUp,
  input  logic                       keyDown,
  input  logic                       keyLeft,
  input  logic                       keyRight,
  input  logic                       keyShoot,
  input  logic signed [10:0]         XspeedIN,
  input  logic signed [10:0]         YspeedIN,
  output logic                       chargeUp,
  output logic                       chargeDown,
  output logic                       chargeLeft,
  output logic                       chargeRight,
  output logic                       releaseBall,
  output logic                       ready,
  output logic signed [CHARGE_W-1:0] chargeX,
  output logic signed [CHARGE_W-1:0] chargeY,
  output logic [7:0]                 shotCount
);

  localparam int REST_W = $clog2(REST_FRAMES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_FRAMES + 1);

  logic rise_up, rise_down, rise_left, rise_right, rise_shoot;
  logic rest;

  key_edge_detect u_edge_up    (.clk(clk), .resetN(resetN), .key(keyUp),    .rise(rise_up));
  key_edge_detect u_edge_down  (.clk(clk), .resetN(resetN), .key(keyDown),  .rise(rise_down));
  key_edge_detect u_edge_left  (.clk(clk), .resetN(resetN), .key(keyLeft),  .rise(rise_left));
  key_edge_detect u_edge_right (.clk(clk), .resetN(resetN), .key(keyRight), .rise(rise_right));
  key_edge_detect u_edge_shoot (.clk(clk), .resetN(resetN), .key(keyShoot), .rise(rise_shoot));

  assign rest = (XspeedIN == 11'sd0) && (YspeedIN == 11'sd0);

  cue_state_t                 state_q, state_d;
  logic [REST_W-1:0]          rest_cnt_q, rest_cnt_d;
  logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic signed [CHARGE_W-1:0] charge_x_q, charge_x_d;
  logic signed [CHARGE_W-1:0] charge_y_q, charge_y_d;
  logic [7:0]                 shot_cnt_q, shot_cnt_d;
  logic                       up_q, up_d, down_q, down_d;
  logic                       left_q, left_d, right_q, right_d;
  logic                       release_q, release_d;
  logic                       ready_q, ready_d;
  axis_step_t                 step_x, step_y;

  always_comb begin
    state_d    = state_q;
    rest_cnt_d = '0;
    tmo_cnt_d  = '0;
    charge_x_d = charge_x_q;
    charge_y_d = charge_y_q;
    shot_cnt_d = shot_cnt_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    left_d     = 1'b0;
    right_d    = 1'b0;
    release_d  = 1'b0;
    step_x     = axis_step(charge_x_q, rise_left, rise_right, MAX_STEPS);
    step_y     = axis_step(charge_y_q, rise_up, rise_down, MAX_STEPS);

    case (state_q)
      WAIT_REST: begin
        if (!rest) begin
          rest_cnt_d = '0;
        end else if (startOfFrame) begin
          if (int'(rest_cnt_q) + 1 >= REST_FRAMES) state_d = AIM;
          else rest_cnt_d = rest_cnt_q + REST_W'(1);
        end else begin
          rest_cnt_d = rest_cnt_q;
        end
      end
      AIM: begin
        // Motion takes priority: any key edges in that cycle are discarded.
        if (!rest) begin
          state_d = WAIT_REST;
        end else if (rise_shoot && (charge_x_q != '0 || charge_y_q != '0)) begin
          state_d    = RELEASE;
          release_d  = 1'b1;
          charge_x_d = '0;
          charge_y_d = '0;
          shot_cnt_d = shot_cnt_q + 8'd1;
        end else begin
          charge_x_d = step_x.next;
          charge_y_d = step_y.next;
          left_d     = step_x.inc;
          right_d    = step_x.dec;
          up_d       = step_y.inc;
          down_d     = step_y.dec;
        end
      end
      RELEASE: begin
        state_d = WAIT_MOVE;
      end
      WAIT_MOVE: begin
        if (!rest) begin
          state_d = WAIT_REST;
        end else if (startOfFrame) begin
          if (int'(tmo_cnt_q) + 1 >= TIMEOUT_FRAMES) state_d = WAIT_REST;
          else tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      default: state_d = WAIT_REST;
    endcase

    ready_d = (state_d == AIM);
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q    <= WAIT_REST;
      rest_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      charge_x_q <= '0;
      charge_y_q <= '0;
      shot_cnt_q <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      release_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rest_cnt_q <= rest_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      charge_x_q <= charge_x_d;
      charge_y_q <= charge_y_d;
      shot_cnt_q <= shot_cnt_d;
      up_q       <= up_d;
      down_q     <= down_d;
      left_q     <= left_d;
      right_q    <= right_d;
      release_q  <= release_d;
      ready_q    <= ready_d;
    end
  end

  assign chargeUp    = up_q;
  assign chargeDown  = down_q;
  assign chargeLeft  = left_q;
  assign chargeRight = right_q;
  assign releaseBall = release_q;
  assign ready       = ready_q;
  assign chargeX     = charge_x_q;
  assign chargeY     = charge_y_q;
  assign shotCount   = shot_cnt_q;

endmodule

// File: tb/tb_shot_cue_controller.sv
// Bench for shot_cue_controller: directed scenarios plus randomized key/speed
// traffic, all cycles compared against a behavioural model of the cue rules.
module tb_shot_cue_controller;

  localparam int MAXS = 5;
  localparam int RESTF = 4;
  localparam int TMOF = 8;

  localparam int M_SETTLE = 0;
  localparam int M_AIM    = 1;
  localparam int M_FIRE   = 2;
  localparam int M_FLIGHT = 3;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic startOfFrame = 1'b0;
  logic [4:0] keys = 5'b0;
  logic signed [10:0] XspeedIN = 11'sd0;
  logic signed [10:0] YspeedIN = 11'sd0;
  logic keyUp, keyDown, keyLeft, keyRight, keyShoot;
  logic chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, ready;
  logic signed [3:0] chargeX, chargeY;
  logic [7:0] shotCount;

  assign keyUp    = keys[0];
  assign keyDown  = keys[1];
  assign keyLeft  = keys[2];
  assign keyRight = keys[3];
  assign keyShoot = keys[4];

  shot_cue_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .keyUp(keyUp), .keyDown(keyDown), .keyLeft(keyLeft), .keyRight(keyRight),
    .keyShoot(keyShoot), .XspeedIN(XspeedIN), .YspeedIN(YspeedIN),
    .chargeUp(chargeUp), .chargeDown(chargeDown), .chargeLeft(chargeLeft),
    .chargeRight(chargeRight), .releaseBall(releaseBall), .ready(ready),
    .chargeX(chargeX), .chargeY(chargeY), .shotCount(shotCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_up = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode of play, frames seen, shot mirrors, key history.
  int m_mode = M_SETTLE;
  int m_frames = 0;
  int m_cx = 0;
  int m_cy = 0;
  int m_shots = 0;
  logic [4:0] m_prev = 5'b0;
  int e_ready = 0;
  int e_pulses = 0;

  task automatic model_step();
    logic [4:0] rise;
    bit rest;
    e_pulses = 0;
    if (resetN) begin
      m_mode = M_SETTLE; m_frames = 0; m_cx = 0; m_cy = 0; m_shots = 0;
      m_prev = 5'b0;
    end else begin
      rise = keys & ~m_prev;
      m_prev = keys;
      rest = (XspeedIN == 0) && (YspeedIN == 0);
      case (m_mode)
        M_SETTLE: begin
          if (!rest) m_frames = 0;
          else if (startOfFrame) begin
            m_frames++;
            if (m_frames == RESTF) m_mode = M_AIM;
          end
        end
        M_AIM: begin
          if (!rest) begin
            m_mode = M_SETTLE; m_frames = 0;
          end else if (rise[4] && (m_cx != 0 || m_cy != 0)) begin
            m_mode = M_FIRE; e_pulses = 1; m_cx = 0; m_cy = 0;
            m_shots = (m_shots + 1) % 256;
          end else begin
            if (rise[0] && !rise[1] && m_cy < MAXS)  begin m_cy++; e_pulses += 16; end
            if (rise[1] && !rise[0] && m_cy > -MAXS) begin m_cy--; e_pulses += 8;  end
            if (rise[2] && !rise[3] && m_cx < MAXS)  begin m_cx++; e_pulses += 4;  end
            if (rise[3] && !rise[2] && m_cx > -MAXS) begin m_cx--; e_pulses += 2;  end
          end
        end
        M_FIRE: begin
          m_mode = M_FLIGHT; m_frames = 0;
        end
        default: begin
          if (!rest) begin
            m_mode = M_SETTLE; m_frames = 0;
          end else if (startOfFrame) begin
            m_frames++;
            if (m_frames == TMOF) begin m_mode = M_SETTLE; m_frames = 0; end
          end
        end
      endcase
    end
    e_ready = (m_mode == M_AIM) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (chargeUp) n_up++;
    check_eq("ready", int'(ready), e_ready);
    check_eq("chargeX", int'(chargeX), m_cx);
    check_eq("chargeY", int'(chargeY), m_cy);
    check_eq("shotCount", int'(shotCount), m_shots);
    check_eq("pulses", int'({chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall}), e_pulses);
  endtask

  task automatic press(input logic [4:0] m);
    keys = keys | m;
    tick();
    keys = keys & ~m;
    tick();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    resetN = 1'b1; keys = 5'b0; startOfFrame = 1'b0;
    XspeedIN = 11'sd0; YspeedIN = 11'sd0;
    tick();
    tick();
    resetN = 1'b0;
  endtask

  int hold;

  initial begin
    // Reset and settle: ready rises on the 4th frame
    do_reset();
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_shots", int'(shotCount), 0);
    check_eq("rst_chargeY", int'(chargeY), 0);
    frames(3);
    check_eq("pre_aim_ready", int'(ready), 0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("aim_ready_4th_frame", int'(ready), 1);

    // Seven up presses saturate at +5
    n_up = 0;
    repeat (7) press(5'b00001);
    check_eq("up_pulse_count", n_up, 5);
    check_eq("chargeY_sat", int'(chargeY), 5);

    // Simultaneous X/Y edges, then cancelling Y edges
    do_reset();
    frames(4);
    keys = 5'b00110;
    tick();
    check_eq("left_down_pulses", int'({chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall}), 5'b01100);
    keys = 5'b0;
    tick();
    check_eq("chargeX_plus1", int'(chargeX), 1);
    check_eq("chargeY_minus1", int'(chargeY), -1);
    keys = 5'b00011;
    tick();
    check_eq("up_down_cancel", int'({chargeUp, chargeDown}), 0);
    keys = 5'b0;
    tick();

    // Shot with chargeX=2, ball starts moving
    press(5'b00100);
    keys = 5'b10000;
    tick();
    check_eq("release_pulse", int'(releaseBall), 1);
    check_eq("shot_one", int'(shotCount), 1);
    check_eq("mirror_x_clear", int'(chargeX), 0);
    keys = 5'b0;
    XspeedIN = 11'sd400;
    tick();
    tick();
    check_eq("moving_not_ready", int'(ready), 0);
    XspeedIN = 11'sd0;

    // Empty shot ignored; shot with no motion times out
    frames(4);
    keys = 5'b10000;
    tick();
    check_eq("empty_shot_no_release", int'(releaseBall), 0);
    check_eq("empty_shot_ready", int'(ready), 1);
    keys = 5'b0;
    tick();
    press(5'b00001);
    keys = 5'b10000;
    tick();
    keys = 5'b0;
    tick();
    frames(11);
    check_eq("timeout_not_yet_ready", int'(ready), 0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("timeout_then_ready", int'(ready), 1);

    // Ball disturbed while aiming; reset during release
    repeat (3) press(5'b00001);
    YspeedIN = -11'sd50;
    tick();
    check_eq("hit_not_ready", int'(ready), 0);
    check_eq("hit_chargeY_held", int'(chargeY), 3);
    YspeedIN = 11'sd0;
    frames(4);
    keys = 5'b10000;
    tick();
    check_eq("release_before_reset", int'(releaseBall), 1);
    keys = 5'b0;
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    check_eq("reset_release_low", int'(releaseBall), 0);
    check_eq("reset_shots_zero", int'(shotCount), 0);
    check_eq("reset_ready_low", int'(ready), 0);

    // Randomized traffic
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      startOfFrame = (cyc % 5 == 0);
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 5) == 0) keys[k] = ~keys[k];
      if (hold > 0) begin
        hold--;
      end else if ($urandom_range(0, 39) == 0) begin
        XspeedIN = 11'($signed($urandom_range(0, 600)) - 300);
        YspeedIN = 11'($signed($urandom_range(0, 600)) - 300);
        hold = $urandom_range(1, 3);
      end else begin
        XspeedIN = 11'sd0;
        YspeedIN = 11'sd0;
      end
      resetN = ($urandom_range(0, 499) == 0);
      tick();
    end
    resetN = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
